// File: rtl/mdu_div_ctrl_pkg.sv
// Shared MDU definitions: divide op encoding, FSM states
// and the constant results returned when the core is bypassed.
package mdu_div_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_MOD  = 2'd2,
        OP_MODU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } div_state_e;

    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT    = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR = 32'hFFFF_FFFF;
    localparam logic [5:0]  WAIT_CYCLES = 6'd32;

    // Signed INT_MIN / -1 overflows and is answered without the core.
    function automatic logic is_signed_ovf(
        input logic        sgn,
        input logic [31:0] a,
        input logic [31:0] b
    );
        return sgn && (a == OVF_QUOT) && (b == OVF_DIVISOR);
    endfunction

endpackage

// File: rtl/divide_high_pace.sv
// 32-cycle restoring divider on magnitudes with sign fix-up.
// Note: o_div_res carries the remainder, o_mod_res the quotient.
module divide_high_pace (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_sign,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic [31:0] o_div_res,
    output logic [31:0] o_mod_res
);

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_negq;
    logic        r_negr;
    logic [31:0] r_qres;
    logic [31:0] r_rres;

    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [32:0] w_sh;
    logic        w_ge;
    logic [31:0] w_rem_n;
    logic [31:0] w_quo_n;

    assign w_sa    = i_sign & i_a[31];
    assign w_sb    = i_sign & i_b[31];
    assign w_ua    = w_sa ? -i_a : i_a;
    assign w_ub    = w_sb ? -i_b : i_b;
    assign w_sh    = {r_rem, r_quo[31]};
    assign w_ge    = w_sh >= {1'b0, r_dvs};
    assign w_rem_n = w_ge ? (w_sh[31:0] - r_dvs) : w_sh[31:0];
    assign w_quo_n = {r_quo[30:0], w_ge};

    assign o_busy    = r_busy;
    assign o_div_res = r_rres;
    assign o_mod_res = r_qres;

    // Load on start, one quotient bit per cycle, sign-correct on the last.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= 5'd0;
            r_rem  <= 32'd0;
            r_quo  <= 32'd0;
            r_dvs  <= 32'd0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_qres <= 32'd0;
            r_rres <= 32'd0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= 5'd0;
            r_rem  <= 32'd0;
            r_quo  <= w_ua;
            r_dvs  <= w_ub;
            r_negq <= w_sa ^ w_sb;
            r_negr <= w_sa;
        end else if (r_busy) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
                r_qres <= r_negq ? -w_quo_n : w_quo_n;
                r_rres <= r_negr ? -w_rem_n : w_rem_n;
            end
        end
    end

endmodule

// File: rtl/mdu_div_ctrl.sv
// Divide controller: handshakes requests, sequences the iterative
// core, bypasses divide-by-zero and signed overflow, handles flush.
module mdu_div_ctrl
    import mdu_div_ctrl_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    div_state_e       r_state;
    div_state_e       w_next;
    logic [5:0]       r_cnt;
    div_op_e          r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;

    logic             w_start;
    logic             w_busy;
    logic [31:0]      w_rem;
    logic [31:0]      w_quo;
    logic             w_accept;
    logic             w_div0;
    logic             w_bypass;
    logic [31:0]      w_byp_data;
    logic             w_cnt_done;
    logic             w_core_done;
    logic             w_capture;

    assign w_accept    = (r_state == S_IDLE) && in_valid && !flush && !rst;
    assign w_div0      = (in_b == 32'd0);
    assign w_bypass    = w_div0 || is_signed_ovf(!in_op[0], in_a, in_b);
    assign w_byp_data  = w_div0 ? (in_op[1] ? in_a : DIV0_QUOT)
                                : (in_op[1] ? 32'd0 : OVF_QUOT);
    assign w_cnt_done  = (r_cnt == WAIT_CYCLES);
    assign w_core_done = w_cnt_done && !w_busy;
    assign w_capture   = (r_state == S_WAIT) && !flush && w_core_done;

    assign out_data = r_data;
    assign out_tag  = r_tag;

    divide_high_pace u_core (
        .i_clk     (clk),
        .i_rst_n   (~rst),
        .i_start   (w_start),
        .i_sign    (~r_op[0]),
        .i_a       (r_a),
        .i_b       (r_b),
        .o_busy    (w_busy),
        .o_div_res (w_rem),
        .o_mod_res (w_quo)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake outputs; flush wins over out_ready.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_start   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = !flush && !rst;
                if (w_accept) w_next = w_bypass ? S_DONE : S_START;
            end
            S_START: begin
                w_start = 1'b1;
                w_next  = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush)            w_next = S_DRAIN;
                else if (w_core_done) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (w_core_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Wait counter: cleared in START, saturates at the core latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 6'd0;
        end else if (r_state == S_START) begin
            r_cnt <= 6'd0;
        end else if ((r_state == S_WAIT || r_state == S_DRAIN) && !w_cnt_done) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // Request latch and result capture; held steady while in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_DIV;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_tag  <= '0;
            r_data <= 32'd0;
        end else if (w_accept) begin
            r_op  <= div_op_e'(in_op);
            r_a   <= in_a;
            r_b   <= in_b;
            r_tag <= in_tag;
            if (w_bypass) r_data <= w_byp_data;
        end else if (w_capture) begin
            r_data <= r_op[1] ? w_rem : w_quo;
        end
    end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Directed bench for mdu_div_ctrl: results, latency, backpressure,
// flush in each state and reset mid-operation.
module tb_mdu_div_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [5:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_tag;

    int n_asserts = 0;
    int n_fail    = 0;

    mdu_div_ctrl #(.TAG_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then present one request for one edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns n where out_valid first seen in cycle A+n (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
    endtask

    task automatic run(input string nm, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] exp,
                       input int exp_lat);
        int lat;
        send(op, a, b, tag);
        wait_valid(lat);
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        check({nm, "_data"}, out_data, exp);
        check({nm, "_tag"}, 32'(out_tag), 32'(tag));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int k;
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 6'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", in_ready, 1);

        run("div_100_m7", 2'd0, 32'd100, 32'hFFFF_FFF9, 6'd5,
            32'hFFFF_FFF2, 35);
        run("mod_m100_7", 2'd2, 32'hFFFF_FF9C, 32'd7, 6'd6,
            32'hFFFF_FFFE, 35);
        run("modu_max_16", 2'd3, 32'hFFFF_FFFF, 32'd16, 6'd7,
            32'h0000_000F, 35);
        run("div_5_0", 2'd0, 32'd5, 32'd0, 6'd8, 32'hFFFF_FFFF, 1);
        run("mod_5_0", 2'd2, 32'd5, 32'd0, 6'd9, 32'd5, 1);
        run("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10,
            32'h8000_0000, 1);
        run("mod_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11,
            32'd0, 1);
        run("divu_no_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12,
            32'd0, 35);

        // Backpressure: result held while out_ready stays low.
        send(2'd1, 32'd1000, 32'd10, 6'd13);
        wait_valid(lat);
        check("hold_lat", 32'(lat), 35);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, 32'd100);
            check("hold_tag", 32'(out_tag), 32'd13);
            check("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Flush during WAIT at A+10: drains silently, idle at A+35.
        send(2'd1, 32'd1000, 32'd3, 6'd14);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 1'b0;
        k = 10;
        do begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1'b1;
        end while (!in_ready && k < 80);
        check("flush_no_valid", seen, 0);
        check("flush_ready_cycle", 32'(k), 35);
        run("divu_9_2", 2'd1, 32'd9, 32'd2, 6'd15, 32'd4, 35);

        // Flush in DONE drops out_valid next cycle.
        send(2'd0, 32'd7, 32'd0, 6'd16);
        @(negedge clk);
        check("done_flush_pre", out_valid, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("done_flush_valid", out_valid, 0);
        check("done_flush_ready", in_ready, 1);

        // Flush together with out_ready in DONE.
        send(2'd0, 32'd7, 32'd0, 6'd17);
        @(negedge clk);
        check("prio_pre", out_valid, 1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("prio_valid", out_valid, 0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_a     = 32'd3;
        in_b     = 32'd0;
        #1 check("idle_flush_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_flush_no_accept", out_valid, 0);

        // Reset at A+20 of a running divide.
        send(2'd0, 32'd1000, 32'hFFFF_FFFD, 6'd18);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_data", out_data, 0);
        check("midrst_tag", 32'(out_tag), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_release", in_ready, 1);
        run("div_m1000_3", 2'd0, 32'hFFFF_FC18, 32'd3, 6'd19,
            32'hFFFF_FEB3, 35);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
